// File: rtl/ele_motion_ctrl.sv
// ele_motion_ctrl: sequencing controller for the 4-storey elevator.
// Tracks the one-hot car position, run direction (ud_mode) and door state,
// timing floor-to-floor travel and door dwell in clk ticks.
// Optional emergency stop enabled by defining ELE_ESTOP_EN.
module ele_motion_ctrl #(
    parameter int unsigned TRAVEL_TICKS = 64,
    parameter int unsigned DOOR_TICKS   = 96
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       up_need,
    input  logic       down_need,
    input  logic [3:0] allReq_reg,
    input  logic       door_hold,
`ifdef ELE_ESTOP_EN
    input  logic       estop,
    output logic       halted,
`endif
    output logic [3:0] position,
    output logic [1:0] ud_mode,
    output logic       door_open,
    output logic       moving
);

    localparam int unsigned MAX_TICKS = (TRAVEL_TICKS > DOOR_TICKS) ? TRAVEL_TICKS : DOOR_TICKS;
    localparam int unsigned TW        = $clog2(MAX_TICKS);
    localparam logic [TW-1:0] TRAVEL_LAST = TW'(TRAVEL_TICKS - 1);
    localparam logic [TW-1:0] DOOR_LAST   = TW'(DOOR_TICKS - 1);

    typedef enum logic [2:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN,
        DOOR,
        DECIDE
    } state_t;

    typedef enum logic [1:0] {
        UD_STOP = 2'b00,
        UD_UP   = 2'b01,
        UD_DOWN = 2'b10
    } udMode_t;

    state_t        state, stateN;
    logic [TW-1:0] timer, timerN;
    logic [3:0]    posN;
    udMode_t       udQ, udN;
    logic          atTop, atBottom;
    logic          canUp, canDown;

    assign atTop    = (position == 4'b1000);
    assign atBottom = (position == 4'b0001);
    assign canUp    = up_need && !atTop;
    assign canDown  = down_need && !atBottom;

    // State, timer, position and direction registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            timer    <= '0;
            position <= 4'b0001;
            udQ      <= UD_STOP;
        end else begin
            state    <= stateN;
            timer    <= timerN;
            position <= posN;
            udQ      <= udN;
        end
    end

    // Next-state, timer, position and direction selection
    always_comb begin
        stateN = state;
        timerN = timer;
        posN   = position;
        udN    = udQ;
        unique case (state)
            IDLE: begin
                if ((allReq_reg & position) != 4'b0000) begin
                    stateN = DOOR;
                    udN    = atTop ? UD_DOWN : UD_UP;
                end else if (canUp) begin
                    stateN = MOVE_UP;
                    udN    = UD_UP;
                end else if (canDown) begin
                    stateN = MOVE_DOWN;
                    udN    = UD_DOWN;
                end else begin
                    udN = UD_STOP;
                end
            end
            MOVE_UP: begin
                if (timer == TRAVEL_LAST) begin
                    posN   = position << 1;
                    timerN = '0;
                    if (((allReq_reg & posN) != 4'b0000) || (posN == 4'b1000))
                        stateN = DOOR;
                end else begin
                    timerN = timer + 1'b1;
                end
            end
            MOVE_DOWN: begin
                if (timer == TRAVEL_LAST) begin
                    posN   = position >> 1;
                    timerN = '0;
                    if (((allReq_reg & posN) != 4'b0000) || (posN == 4'b0001))
                        stateN = DOOR;
                end else begin
                    timerN = timer + 1'b1;
                end
            end
            DOOR: begin
                if (door_hold)
                    timerN = '0;
                else if (timer == DOOR_LAST)
                    stateN = DECIDE;
                else
                    timerN = timer + 1'b1;
            end
            DECIDE: begin
                if (udQ == UD_UP && canUp) begin
                    stateN = MOVE_UP;
                end else if (udQ == UD_DOWN && canDown) begin
                    stateN = MOVE_DOWN;
                end else if (canUp) begin
                    stateN = MOVE_UP;
                    udN    = UD_UP;
                end else if (canDown) begin
                    stateN = MOVE_DOWN;
                    udN    = UD_DOWN;
                end else begin
                    stateN = IDLE;
                    udN    = UD_STOP;
                end
            end
            default: begin
                stateN = IDLE;
                udN    = UD_STOP;
            end
        endcase
        if (stateN != state)
            timerN = '0;
`ifdef ELE_ESTOP_EN
        // Emergency stop overrides every decision above: freeze in place,
        // door dwell pinned at zero so it restarts in full on release.
        if (estop) begin
            stateN = state;
            posN   = position;
            udN    = udQ;
            timerN = (state == DOOR) ? '0 : timer;
        end
`endif
    end

    assign ud_mode   = udQ;
    assign door_open = (state == DOOR);
`ifdef ELE_ESTOP_EN
    assign moving = ((state == MOVE_UP) || (state == MOVE_DOWN)) && !estop;
    assign halted = ((state == MOVE_UP) || (state == MOVE_DOWN)) && estop;
`else
    assign moving = (state == MOVE_UP) || (state == MOVE_DOWN);
`endif

endmodule

// File: tb/tb_ele_motion_ctrl.sv
// Self-checking bench for ele_motion_ctrl with TRAVEL_TICKS=4, DOOR_TICKS=3.
// Directed vector table, hand sequences, and random stimulus against a
// floor/direction/countdown reference model.
module tb_ele_motion_ctrl;

    localparam int T_TICKS = 4;
    localparam int D_TICKS = 3;

    logic       clk;
    logic       rst;
    logic       up_need;
    logic       down_need;
    logic [3:0] allReq_reg;
    logic       door_hold;
    logic [3:0] position;
    logic [1:0] ud_mode;
    logic       door_open;
    logic       moving;
`ifdef ELE_ESTOP_EN
    logic       estop;
    logic       halted;
`endif

    int nChecks = 0;
    int nFail   = 0;

    ele_motion_ctrl #(
        .TRAVEL_TICKS(T_TICKS),
        .DOOR_TICKS  (D_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .up_need   (up_need),
        .down_need (down_need),
        .allReq_reg(allReq_reg),
        .door_hold (door_hold),
`ifdef ELE_ESTOP_EN
        .estop     (estop),
        .halted    (halted),
`endif
        .position  (position),
        .ud_mode   (ud_mode),
        .door_open (door_open),
        .moving    (moving)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: floor index 0..3, direction +1/-1/0, activity, elapsed ticks
    localparam int P_IDLE = 0, P_TRAVEL = 1, P_DOOR = 2, P_DECIDE = 3;
    int mFloor = 0;
    int mDir   = 0;
    int mPhase = P_IDLE;
    int mCnt   = 0;

    task automatic modelStep();
        bit goUp, goDn;
        goUp = up_need && (mFloor < 3);
        goDn = down_need && (mFloor > 0);
        if (rst) begin
            mFloor = 0; mDir = 0; mPhase = P_IDLE; mCnt = 0;
        end else begin
            case (mPhase)
                P_IDLE: begin
                    mCnt = 0;
                    if (allReq_reg[mFloor]) begin
                        mPhase = P_DOOR;
                        mDir   = (mFloor == 3) ? -1 : 1;
                    end else if (goUp) begin
                        mPhase = P_TRAVEL; mDir = 1;
                    end else if (goDn) begin
                        mPhase = P_TRAVEL; mDir = -1;
                    end else begin
                        mDir = 0;
                    end
                end
                P_TRAVEL: begin
                    mCnt++;
                    if (mCnt == T_TICKS) begin
                        mCnt   = 0;
                        mFloor = mFloor + mDir;
                        nChecks++;
                        if (mFloor < 0 || mFloor > 3) begin
                            nFail++;
                            $display("FAIL shift_range: floor index %0d, required 0..3", mFloor);
                            mFloor = (mFloor < 0) ? 0 : 3;
                        end
                        if (allReq_reg[mFloor] || mFloor == ((mDir > 0) ? 3 : 0))
                            mPhase = P_DOOR;
                    end
                end
                P_DOOR: begin
                    if (door_hold) begin
                        mCnt = 0;
                    end else begin
                        mCnt++;
                        if (mCnt == D_TICKS) begin
                            mCnt = 0; mPhase = P_DECIDE;
                        end
                    end
                end
                default: begin
                    mCnt = 0;
                    if (mDir > 0 && goUp)       mPhase = P_TRAVEL;
                    else if (mDir < 0 && goDn)  mPhase = P_TRAVEL;
                    else if (goUp) begin mPhase = P_TRAVEL; mDir = 1;  end
                    else if (goDn) begin mPhase = P_TRAVEL; mDir = -1; end
                    else begin mPhase = P_IDLE; mDir = 0; end
                end
            endcase
        end
    endtask

    task automatic checkOut(input string name, input logic [3:0] ePos, input logic [1:0] eUd,
                            input logic eDoor, input logic eMov);
        nChecks++;
        if (position !== ePos || ud_mode !== eUd || door_open !== eDoor || moving !== eMov) begin
            nFail++;
            $display("FAIL %s: got pos=%b ud=%b door=%b mov=%b, required pos=%b ud=%b door=%b mov=%b",
                     name, position, ud_mode, door_open, moving, ePos, eUd, eDoor, eMov);
        end
    endtask

    task automatic checkModel(input string name);
        logic [3:0] ePos;
        logic [1:0] eUd;
        ePos = 4'b0001 << mFloor;
        eUd  = (mDir > 0) ? 2'b01 : (mDir < 0) ? 2'b10 : 2'b00;
        checkOut(name, ePos, eUd, mPhase == P_DOOR, mPhase == P_TRAVEL);
    endtask

    // Drive inputs on the falling edge, advance the model on the rising edge,
    // compare 1 time unit later
    task automatic applyCycle(input logic r, input logic up, input logic dn,
                              input logic [3:0] req, input logic hold, input string name);
        @(negedge clk);
        rst = r; up_need = up; down_need = dn; allReq_reg = req; door_hold = hold;
        @(posedge clk);
        modelStep();
        #1;
        checkModel(name);
    endtask

    typedef struct {
        logic       r, up, dn;
        logic [3:0] req;
        logic       hold;
        logic [3:0] pos;
        logic [1:0] ud;
        logic       door, mov;
    } vec_t;

    vec_t vq[$];

    initial begin
        rst = 1'b1; up_need = 1'b0; down_need = 1'b0; allReq_reg = 4'b0000; door_hold = 1'b0;
`ifdef ELE_ESTOP_EN
        estop = 1'b0;
`endif
        // r up dn req hold | pos ud door mov
        vq.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0}); // 0 reset
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0001, 2'b01, 1'b0, 1'b1}); // 1 MOVE_UP
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0001, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0001, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0001, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0010, 2'b01, 1'b0, 1'b1}); // 5 +4
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0010, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0010, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0010, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0100, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0}); // 9 +8, DOOR
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b0}); // 12 DECIDE
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b00, 1'b0, 1'b0}); // 13 IDLE
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0}); // 14 DOOR in place
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0100, 2'b01, 1'b1, 1'b0}); // 16 hold
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b1, 1'b0}); // 18 fifth cycle
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b0}); // 19 DECIDE
        vq.push_back('{1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b1}); // 20 MOVE_UP
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0100, 2'b01, 1'b0, 1'b1});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 2'b01, 1'b1, 1'b0}); // 24 forced stop
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 2'b01, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 2'b01, 1'b1, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b1000, 2'b01, 1'b0, 1'b0}); // 27 DECIDE
        vq.push_back('{1'b0, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b1000, 2'b10, 1'b0, 1'b1}); // 28 MOVE_DOWN
        vq.push_back('{1'b1, 1'b0, 1'b1, 4'b0000, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0}); // 29 reset abort
        vq.push_back('{1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0001, 2'b00, 1'b0, 1'b0});
        vq.push_back('{1'b0, 1'b0, 1'b0, 4'b0001, 1'b0, 4'b0001, 2'b01, 1'b1, 1'b0}); // 31 DOOR floor 1

        foreach (vq[i]) begin
            applyCycle(vq[i].r, vq[i].up, vq[i].dn, vq[i].req, vq[i].hold, $sformatf("model_vec%0d", i));
            checkOut($sformatf("vec%0d", i), vq[i].pos, vq[i].ud, vq[i].door, vq[i].mov);
        end

        // Floor 4 in IDLE with a request there opens the door with ud_mode=10
        applyCycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "top_rst");
        for (int i = 0; i < 13; i++)
            applyCycle(1'b0, 1'b1, 1'b0, 4'b1000, 1'b0, "top_travel");
        checkOut("top_arrive", 4'b1000, 2'b01, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++)
            applyCycle(1'b0, 1'b0, 1'b0, 4'b0000, 1'b0, "top_settle");
        checkOut("top_idle", 4'b1000, 2'b00, 1'b0, 1'b0);
        applyCycle(1'b0, 1'b0, 1'b0, 4'b1000, 1'b0, "top_door");
        checkOut("top_door_dir", 4'b1000, 2'b10, 1'b1, 1'b0);

        // Reset held two cycles in the middle of an upward move
        applyCycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "mid_rst0");
        applyCycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_up0");
        applyCycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_up1");
        applyCycle(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_rst1");
        checkOut("mid_rst_abort", 4'b0001, 2'b00, 1'b0, 1'b0);
        applyCycle(1'b1, 1'b1, 1'b0, 4'b0000, 1'b0, "mid_rst2");

        // Random stimulus against the model
        for (int i = 0; i < 4000; i++) begin
            logic [3:0] req;
            req = ($urandom_range(0, 3) == 0) ? (4'b0001 << $urandom_range(0, 3)) : 4'b0000;
            applyCycle(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1,
                       $urandom_range(0, 1) == 1, req, ($urandom_range(0, 5) == 0), "random");
        end

`ifdef ELE_ESTOP_EN
        // Emergency stop at MOVE_UP timer=2 freezes travel; resume steps 2 cycles later
        applyCycle(1'b1, 1'b0, 1'b0, 4'b0000, 1'b0, "es_rst");
        applyCycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "es_up0");
        applyCycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "es_up1");
        applyCycle(1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, "es_up2");
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            estop = 1'b1;
            @(posedge clk);
            #1;
        end
        nChecks++;
        if (position !== 4'b0001 || halted !== 1'b1 || moving !== 1'b0) begin
            nFail++;
            $display("FAIL estop_hold: got pos=%b halted=%b mov=%b, required pos=0001 halted=1 mov=0",
                     position, halted, moving);
        end
        @(negedge clk);
        estop = 1'b0;
        @(posedge clk);
        #1;
        checkOut("estop_resume1", 4'b0001, 2'b01, 1'b0, 1'b1);
        @(posedge clk);
        #1;
        checkOut("estop_resume2", 4'b0010, 2'b01, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
